// File: rtl/alu_op_sequencer.sv
// Command sequencer for a combinational four-function ALU: it owns a small register
// file, issues registered operands, captures Sum and returns the result over valid/ready.
module alu_op_sequencer #(
    parameter int WIDTH      = 5,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_rd,
    input  logic [REG_ADDR_W-1:0] cmd_rs1,
    input  logic [REG_ADDR_W-1:0] cmd_rs2,
    input  logic [WIDTH-1:0]      cmd_imm,
    output logic [WIDTH-1:0]      A,
    output logic [WIDTH-1:0]      B,
    output logic [1:0]            Select,
    input  logic [WIDTH-1:0]      Sum,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_zero,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    localparam logic [2:0] OP_LOADI = 3'd4;
    localparam logic [2:0] OP_READ  = 3'd5;
    localparam int         NREGS    = 2 ** REG_ADDR_W;

    state_t                state, state_next;
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q, rs1_q, rs2_q;
    logic [WIDTH-1:0]      imm_q;
    logic [WIDTH-1:0]      regs [NREGS];
    logic [WIDTH-1:0]      result;
    logic                  wr_en;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cmd_valid) state_next = cmd_op[2] ? CAPTURE : ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ops 0-3 have op[2] clear; Sum is only meaningful in CAPTURE, one cycle after ISSUE.
    always_comb begin
        result = '0;
        wr_en  = 1'b0;
        if (!op_q[2]) begin
            result = Sum;
            wr_en  = 1'b1;
        end else if (op_q == OP_LOADI) begin
            result = imm_q;
            wr_en  = 1'b1;
        end else if (op_q == OP_READ) begin
            result = regs[rs1_q];
        end
    end

    assign cmd_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    // NOTE: the register file is tiny and must read back as zero after reset, so it is reset like any flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            A         <= '0;
            B         <= '0;
            Select    <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                op_q  <= cmd_op;
                rd_q  <= cmd_rd;
                rs1_q <= cmd_rs1;
                rs2_q <= cmd_rs2;
                imm_q <= cmd_imm;
            end
            if (state == ISSUE) begin
                A      <= regs[rs1_q];
                B      <= regs[rs2_q];
                Select <= op_q[1:0];
            end
            if (state == CAPTURE) begin
                if (wr_en) regs[rd_q] <= result;
                rsp_data  <= result;
                rsp_zero  <= (result == '0);
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; the external ALU is modelled inline and
// every expected result is a hand-computed constant.
module tb_alu_op_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [4:0] cmd_imm = '0;
    logic [4:0] A, B, Sum;
    logic [1:0] Select;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [4:0] rsp_data;
    logic       rsp_zero;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] last_a = '0, last_b = '0;
    logic [1:0] last_sel = '0;

    alu_op_sequencer #(.WIDTH(5), .REG_ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .A(A), .B(B), .Select(Select), .Sum(Sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // External combinational ALU.
    always_comb begin
        case (Select)
            2'b00:   Sum = A & B;
            2'b01:   Sum = A + B;
            2'b10:   Sum = A | B;
            default: Sum = A ^ B;
        endcase
    end

    task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic [4:0] imm,
                          input logic [4:0] ea, input logic [4:0] eb, input logic [1:0] es,
                          input logic [4:0] ed, input string name);
        int n;
        int lat;
        int exp_lat;
        logic ez;
        ez = (ed == 5'd0);
        exp_lat = op[2] ? 1 : 2;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (!cmd_ready) begin
            n_bad++;
            $display("FAIL %s ready_timeout: cmd_ready=%b required 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges required %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (rsp_data !== ed) begin
            n_bad++;
            $display("FAIL %s rsp_data: got %h required %h", name, rsp_data, ed);
        end
        n_cmp++;
        if (rsp_zero !== ez) begin
            n_bad++;
            $display("FAIL %s rsp_zero: got %b required %b", name, rsp_zero, ez);
        end
        n_cmp++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s resp_flags: busy=%b cmd_ready=%b required 1/0", name, busy, cmd_ready);
        end
        if (!op[2]) begin
            last_a = ea; last_b = eb; last_sel = es;
        end
        n_cmp++;
        if (A !== last_a || B !== last_b || Select !== last_sel) begin
            n_bad++;
            $display("FAIL %s alu_inputs: A=%h B=%h Sel=%b required %h %h %b",
                     name, A, B, Select, last_a, last_b, last_sel);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s handshake: rsp_valid=%b cmd_ready=%b required 0/1", name, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: ready=%b busy=%b rsp_valid=%b required 0/0/0", cmd_ready, busy, rsp_valid);
        end
        n_cmp++;
        if (A !== 5'd0 || B !== 5'd0 || Select !== 2'd0 || rsp_data !== 5'd0 || rsp_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: A=%h B=%h Sel=%b data=%h zero=%b required all 0",
                     A, B, Select, rsp_data, rsp_zero);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_add();
        do_cmd(3'd4, 2'd0, 2'd0, 2'd0, 5'h0C, 5'h00, 5'h00, 2'd0, 5'h0C, "loadi_r0");
        do_cmd(3'd4, 2'd1, 2'd0, 2'd0, 5'h0A, 5'h00, 5'h00, 2'd0, 5'h0A, "loadi_r1");
        do_cmd(3'd1, 2'd2, 2'd0, 2'd1, 5'h00, 5'h0C, 5'h0A, 2'd1, 5'h16, "add_r2");
    endtask

    task automatic test_wrap();
        do_cmd(3'd4, 2'd3, 2'd0, 2'd0, 5'h1F, 5'h00, 5'h00, 2'd0, 5'h1F, "loadi_r3");
        do_cmd(3'd4, 2'd1, 2'd0, 2'd0, 5'h01, 5'h00, 5'h00, 2'd0, 5'h01, "loadi_r1b");
        do_cmd(3'd1, 2'd3, 2'd3, 2'd1, 5'h00, 5'h1F, 5'h01, 2'd1, 5'h00, "add_wrap");
        do_cmd(3'd5, 2'd0, 2'd3, 2'd0, 5'h00, 5'h00, 5'h00, 2'd0, 5'h00, "read_r3");
    endtask

    task automatic test_logic_ops();
        do_cmd(3'd4, 2'd1, 2'd0, 2'd0, 5'h0A, 5'h00, 5'h00, 2'd0, 5'h0A, "loadi_r1c");
        do_cmd(3'd0, 2'd2, 2'd0, 2'd1, 5'h00, 5'h0C, 5'h0A, 2'd0, 5'h08, "and");
        do_cmd(3'd2, 2'd2, 2'd0, 2'd1, 5'h00, 5'h0C, 5'h0A, 2'd2, 5'h0E, "or");
        do_cmd(3'd3, 2'd2, 2'd0, 2'd1, 5'h00, 5'h0C, 5'h0A, 2'd3, 5'h06, "xor");
        do_cmd(3'd3, 2'd0, 2'd0, 2'd0, 5'h00, 5'h0C, 5'h0C, 2'd3, 5'h00, "xor_self");
        do_cmd(3'd5, 2'd0, 2'd0, 2'd0, 5'h00, 5'h00, 5'h00, 2'd0, 5'h00, "read_r0");
    endtask

    task automatic test_backpressure();
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_rd = 2'd1; cmd_imm = 5'h15;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 5'h15 || rsp_zero !== 1'b0 || cmd_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: valid=%b data=%h zero=%b ready=%b required 1/15/0/0",
                         i, rsp_valid, rsp_data, rsp_zero, cmd_ready);
            end
            if (i == 1) begin
                cmd_valid = 1'b1; cmd_op = 3'd4; cmd_rd = 2'd2; cmd_imm = 5'h1B;
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: valid=%b ready=%b busy=%b required 0/1/0", rsp_valid, cmd_ready, busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_single_handshake: valid=%b busy=%b required 0/0", rsp_valid, busy);
        end
        do_cmd(3'd5, 2'd0, 2'd2, 2'd0, 5'h00, 5'h00, 5'h00, 2'd0, 5'h06, "bp_read_r2");
        do_cmd(3'd5, 2'd0, 2'd1, 2'd0, 5'h00, 5'h00, 5'h00, 2'd0, 5'h15, "bp_read_r1");
    endtask

    task automatic test_reset_mid_op();
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (B !== 5'h15 || Select !== 2'd1) begin
            n_bad++;
            $display("FAIL mid_issue: B=%h Sel=%b required 15/01", B, Select);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || B !== 5'h00 ||
            Select !== 2'd0 || rsp_data !== 5'h00 || rsp_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: valid=%b busy=%b ready=%b B=%h Sel=%b data=%h zero=%b required all 0",
                     rsp_valid, busy, cmd_ready, B, Select, rsp_data, rsp_zero);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_no_response: rsp_valid=%b required 0", rsp_valid);
        end
        last_a = '0; last_b = '0; last_sel = '0;
        do_cmd(3'd5, 2'd0, 2'd2, 2'd0, 5'h00, 5'h00, 5'h00, 2'd0, 5'h00, "mid_read_r2");
        do_cmd(3'd5, 2'd0, 2'd1, 2'd0, 5'h00, 5'h00, 5'h00, 2'd0, 5'h00, "mid_read_r1");
    endtask

    task automatic test_nop();
        do_cmd(3'd4, 2'd1, 2'd0, 2'd0, 5'h09, 5'h00, 5'h00, 2'd0, 5'h09, "nop_loadi_r1");
        do_cmd(3'd1, 2'd3, 2'd1, 2'd1, 5'h00, 5'h09, 5'h09, 2'd1, 5'h12, "nop_add_r3");
        do_cmd(3'd6, 2'd1, 2'd1, 2'd1, 5'h1E, 5'h00, 5'h00, 2'd0, 5'h00, "nop6");
        do_cmd(3'd7, 2'd1, 2'd1, 2'd1, 5'h1E, 5'h00, 5'h00, 2'd0, 5'h00, "nop7");
        do_cmd(3'd5, 2'd0, 2'd1, 2'd0, 5'h00, 5'h00, 5'h00, 2'd0, 5'h09, "nop_read_r1");
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_logic_ops();
        test_backpressure();
        test_reset_mid_op();
        test_nop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
